// File: rtl/ghash_digit_serial_ctrl_if.sv
// Block-in / result-out handshake bundle for the digit-serial GHASH controller.
// The slave modport is the engine side; the master modport is the formatter/tag side.
interface ghash_digit_serial_ctrl_if #(
    parameter int NB_DATA = 128
);
    logic [NB_DATA-1:0] i_h_key;
    logic               i_h_load;
    logic [NB_DATA-1:0] i_data;
    logic               i_sop;
    logic               i_eop;
    logic               i_valid;
    logic               o_ready;
    logic [NB_DATA-1:0] o_ghash;
    logic               o_valid;
    logic               i_ready;
    logic [31:0]        o_nblocks;

    modport slave (
        input  i_h_key, i_h_load, i_data, i_sop, i_eop, i_valid, i_ready,
        output o_ready, o_ghash, o_valid, o_nblocks
    );

    modport master (
        output i_h_key, i_h_load, i_data, i_sop, i_eop, i_valid, i_ready,
        input  o_ready, o_ghash, o_valid, o_nblocks
    );
endinterface

// File: rtl/ghash_digit_serial_ctrl.sv
// Digit-serial GHASH engine: Y = (Y ^ X) * H in GF(2^128), NB_STEP multiplier bits per cycle.
// Optional macro GHASH_CTRL_BLOCK_COUNT_EN adds a saturating per-message block counter on o_nblocks.
module ghash_digit_serial_ctrl #(
    parameter int NB_DATA = 128,
    parameter int NB_STEP = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    ghash_digit_serial_ctrl_if.slave  bus
);
    localparam int K      = NB_DATA / NB_STEP;
    localparam int NB_CNT = (K > 1) ? $clog2(K) : 1;
    localparam logic [NB_DATA-1:0] R = {8'hE1, {(NB_DATA-8){1'b0}}};

    generate
        if (NB_DATA != 128 || NB_STEP < 1 || NB_STEP > 32 || (128 % NB_STEP) != 0) begin : g_bad_cfg
            $error("ghash_digit_serial_ctrl: illegal NB_DATA/NB_STEP configuration");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [NB_DATA-1:0]  r_h;
    logic [NB_DATA-1:0]  r_y;
    logic [NB_DATA-1:0]  r_z;
    logic [NB_DATA-1:0]  r_v;
    logic [NB_DATA-1:0]  r_a;
    logic [NB_CNT-1:0]   r_cnt;
    logic                r_eop;
    logic                r_valid;
    logic [NB_DATA-1:0]  r_ghash;

    logic [2*NB_DATA-1:0] w_step;
    logic [NB_DATA-1:0]   w_z_next;
    logic [NB_DATA-1:0]   w_v_next;
    logic                 w_accept;
    logic                 w_last;

    // One digit of the shift-and-add multiply; V is advanced by x with reduction after every bit.
    function automatic logic [2*NB_DATA-1:0] gf_digit(
        input logic [NB_DATA-1:0] z_in,
        input logic [NB_DATA-1:0] v_in,
        input logic [NB_STEP-1:0] digit
    );
        logic [NB_DATA-1:0] z;
        logic [NB_DATA-1:0] v;
        z = z_in;
        v = v_in;
        for (int i = 0; i < NB_STEP; i++) begin
            if (digit[NB_STEP-1-i]) begin
                z = z ^ v;
            end
            v = v[0] ? ((v >> 1) ^ R) : (v >> 1);
        end
        return {z, v};
    endfunction

    always_comb begin
        w_step   = gf_digit(r_z, r_v, r_a[NB_DATA-1 -: NB_STEP]);
        w_z_next = w_step[2*NB_DATA-1:NB_DATA];
        w_v_next = w_step[NB_DATA-1:0];
    end

    assign w_accept = bus.i_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == NB_CNT'(K - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_v     <= '0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_eop   <= 1'b0;
            r_valid <= 1'b0;
            r_ghash <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_h_load) begin
                        r_h <= bus.i_h_key;
                    end
                    if (w_accept) begin
                        r_a     <= bus.i_data ^ (bus.i_sop ? '0 : r_y);
                        r_z     <= '0;
                        r_v     <= bus.i_h_load ? bus.i_h_key : r_h;
                        r_cnt   <= '0;
                        r_eop   <= bus.i_eop;
                        r_state <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    r_z   <= w_z_next;
                    r_v   <= w_v_next;
                    r_a   <= r_a << NB_STEP;
                    r_cnt <= r_cnt + NB_CNT'(1);
                    if (w_last) begin
                        r_y <= w_z_next;
                        if (r_eop) begin
                            r_ghash <= w_z_next;
                            r_valid <= 1'b1;
                            r_state <= ST_OUT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ready = (r_state == ST_IDLE);
    assign bus.o_valid = r_valid;
    assign bus.o_ghash = r_ghash;

`ifdef GHASH_CTRL_BLOCK_COUNT_EN
    logic [31:0] r_blk_cnt;
    logic [31:0] r_nblocks;

    // The count already includes the eop block by the time its multiply finishes.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_blk_cnt <= '0;
            r_nblocks <= '0;
        end else begin
            if (w_accept) begin
                if (bus.i_sop) begin
                    r_blk_cnt <= 32'd1;
                end else if (r_blk_cnt != 32'hFFFF_FFFF) begin
                    r_blk_cnt <= r_blk_cnt + 32'd1;
                end
            end
            if ((r_state == ST_MULT) && w_last && r_eop) begin
                r_nblocks <= r_blk_cnt;
            end
        end
    end

    assign bus.o_nblocks = r_nblocks;
`else
    assign bus.o_nblocks = '0;
`endif

endmodule

// File: tb/tb_ghash_digit_serial_ctrl.sv
// Directed bench for ghash_digit_serial_ctrl: vector table of single-block products,
// plus chaining, backpressure, mid-multiply reset and an NB_STEP sweep.
module tb_ghash_digit_serial_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] H_ID  = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] H_X1  = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] H_127 = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] X_ID  = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [127:0] P_RED = 128'hE100_0000_0000_0000_0000_0000_0000_0000;

`ifdef GHASH_CTRL_BLOCK_COUNT_EN
    localparam int NB1 = 1, NB2 = 2, NB3 = 3;
`else
    localparam int NB1 = 0, NB2 = 0, NB3 = 0;
`endif

    ghash_digit_serial_ctrl_if #(.NB_DATA(128)) bus ();
    ghash_digit_serial_ctrl #(.NB_DATA(128), .NB_STEP(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    // Sweep instances share one stimulus set.
    logic [127:0] s_hkey, s_data;
    logic         s_hload, s_sop, s_eop, s_valid, s_ready;
    ghash_digit_serial_ctrl_if #(.NB_DATA(128)) sw1_if ();
    ghash_digit_serial_ctrl_if #(.NB_DATA(128)) sw4_if ();
    ghash_digit_serial_ctrl_if #(.NB_DATA(128)) sw32_if ();
    assign sw1_if.i_h_key  = s_hkey;  assign sw4_if.i_h_key  = s_hkey;  assign sw32_if.i_h_key  = s_hkey;
    assign sw1_if.i_h_load = s_hload; assign sw4_if.i_h_load = s_hload; assign sw32_if.i_h_load = s_hload;
    assign sw1_if.i_data   = s_data;  assign sw4_if.i_data   = s_data;  assign sw32_if.i_data   = s_data;
    assign sw1_if.i_sop    = s_sop;   assign sw4_if.i_sop    = s_sop;   assign sw32_if.i_sop    = s_sop;
    assign sw1_if.i_eop    = s_eop;   assign sw4_if.i_eop    = s_eop;   assign sw32_if.i_eop    = s_eop;
    assign sw1_if.i_valid  = s_valid; assign sw4_if.i_valid  = s_valid; assign sw32_if.i_valid  = s_valid;
    assign sw1_if.i_ready  = s_ready; assign sw4_if.i_ready  = s_ready; assign sw32_if.i_ready  = s_ready;

    ghash_digit_serial_ctrl #(.NB_DATA(128), .NB_STEP(1))  dut_s1  (.i_clock(clk), .i_reset(rst), .bus(sw1_if.slave));
    ghash_digit_serial_ctrl #(.NB_DATA(128), .NB_STEP(4))  dut_s4  (.i_clock(clk), .i_reset(rst), .bus(sw4_if.slave));
    ghash_digit_serial_ctrl #(.NB_DATA(128), .NB_STEP(32)) dut_s32 (.i_clock(clk), .i_reset(rst), .bus(sw32_if.slave));

    typedef struct {
        logic [127:0] h;
        logic [127:0] x;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid  = 1'b0;
        bus.i_sop    = 1'b0;
        bus.i_eop    = 1'b0;
        bus.i_h_load = 1'b0;
    endtask

    // Presents one block, then counts edges until o_valid (eop) or o_ready (non-eop).
    task automatic send(input logic [127:0] key, input logic load, input logic [127:0] x,
                        input logic sop, input logic eop, output int lat);
        bus.i_h_key  = key;
        bus.i_h_load = load;
        bus.i_data   = x;
        bus.i_sop    = sop;
        bus.i_eop    = eop;
        bus.i_valid  = 1'b1;
        tick();
        idle_inputs();
        lat = 0;
        while (lat < 300) begin
            tick();
            lat++;
            if (eop ? bus.o_valid : bus.o_ready) break;
        end
    endtask

    task automatic release_out();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

    int lat;
    int l1, l4, l32;

    initial begin
        tbl[0] = '{H_ID,  X_ID,  X_ID};
        tbl[1] = '{H_127, H_X1,  P_RED};
        tbl[2] = '{H_X1,  H_ID,  H_X1};
        tbl[3] = '{H_ID,  {128{1'b1}}, {128{1'b1}}};
        tbl[4] = '{H_127, 128'h2000_0000_0000_0000_0000_0000_0000_0000, 128'h7080_0000_0000_0000_0000_0000_0000_0000};
        tbl[5] = '{128'h0, X_ID, 128'h0};

        bus.i_h_key = '0; bus.i_data = '0; bus.i_ready = 1'b0;
        idle_inputs();
        s_hkey = '0; s_data = '0; s_hload = 0; s_sop = 0; s_eop = 0; s_valid = 0; s_ready = 0;

        tick();
        tick();
        check("rst_ready",   128'(bus.o_ready),   128'd1);
        check("rst_valid",   128'(bus.o_valid),   128'd0);
        check("rst_ghash",   bus.o_ghash,         128'd0);
        check("rst_nblocks", 128'(bus.o_nblocks), 128'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].h, 1'b1, tbl[i].x, 1'b1, 1'b1, lat);
            check($sformatf("vec%0d_ghash", i), bus.o_ghash, tbl[i].exp);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'd16);
            check($sformatf("vec%0d_nblk", i), 128'(bus.o_nblocks), 128'(NB1));
            check($sformatf("vec%0d_rdy_out", i), 128'(bus.o_ready), 128'd0);
            release_out();
            check($sformatf("vec%0d_valid_clr", i), 128'(bus.o_valid), 128'd0);
            check($sformatf("vec%0d_rdy_back", i), 128'(bus.o_ready), 128'd1);
        end

        // Two-block message, then a sop-less block chaining from its result.
        send(H_ID, 1'b1, 128'hFF00_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, lat);
        check("chain_b1_lat", 128'(lat), 128'd16);
        check("chain_b1_novalid", 128'(bus.o_valid), 128'd0);
        send(H_ID, 1'b0, 128'h00FF_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, lat);
        check("chain_b2_lat", 128'(lat), 128'd16);
        check("chain_ghash", bus.o_ghash, 128'hFFFF_0000_0000_0000_0000_0000_0000_0000);
        check("chain_nblk", 128'(bus.o_nblocks), 128'(NB2));
        release_out();
        send(H_ID, 1'b0, 128'h0, 1'b0, 1'b1, lat);
        check("chain_cont_ghash", bus.o_ghash, 128'hFFFF_0000_0000_0000_0000_0000_0000_0000);
        check("chain_cont_nblk", 128'(bus.o_nblocks), 128'(NB3));
        release_out();

        // Backpressure with an attempted key load while the result is held.
        send(H_ID, 1'b1, X_ID, 1'b1, 1'b1, lat);
        bus.i_h_key  = '0;
        bus.i_h_load = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), {bus.o_valid, bus.o_ready, bus.o_ghash[125:0]},
                  {1'b1, 1'b0, X_ID[125:0]});
        end
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready  = 1'b0;
        bus.i_h_load = 1'b0;
        check("bp_released", 128'(bus.o_valid), 128'd0);
        send(128'h0, 1'b0, 128'h0F0F_0000_0000_0000_0000_0000_0000_1234, 1'b1, 1'b1, lat);
        check("bp_key_kept", bus.o_ghash, 128'h0F0F_0000_0000_0000_0000_0000_0000_1234);
        release_out();

        // Reset five digits into a multiply.
        bus.i_h_key = H_ID; bus.i_h_load = 1'b1; bus.i_data = X_ID;
        bus.i_sop = 1'b1; bus.i_eop = 1'b1; bus.i_valid = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 5; c++) tick();
        check("mid_busy", 128'(bus.o_ready), 128'd0);
        rst = 1'b1;
        #1;
        check("mr_ready",   128'(bus.o_ready),   128'd1);
        check("mr_valid",   128'(bus.o_valid),   128'd0);
        check("mr_ghash",   bus.o_ghash,         128'd0);
        check("mr_nblocks", 128'(bus.o_nblocks), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        send(H_ID, 1'b0, X_ID, 1'b1, 1'b1, lat);
        check("mr_hzero_ghash", bus.o_ghash, 128'd0);
        check("mr_hzero_lat", 128'(lat), 128'd16);
        release_out();

        // NB_STEP sweep on the reduction case.
        s_hkey = H_127; s_hload = 1'b1; s_data = H_X1; s_sop = 1'b1; s_eop = 1'b1; s_valid = 1'b1;
        tick();
        s_hload = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_valid = 1'b0;
        l1 = -1; l4 = -1; l32 = -1;
        for (int c = 1; c <= 140; c++) begin
            tick();
            if (l1  < 0 && sw1_if.o_valid)  l1  = c;
            if (l4  < 0 && sw4_if.o_valid)  l4  = c;
            if (l32 < 0 && sw32_if.o_valid) l32 = c;
        end
        check("sw1_lat",    128'(l1),  128'd128);
        check("sw4_lat",    128'(l4),  128'd32);
        check("sw32_lat",   128'(l32), 128'd4);
        check("sw1_ghash",  sw1_if.o_ghash,  P_RED);
        check("sw4_ghash",  sw4_if.o_ghash,  P_RED);
        check("sw32_ghash", sw32_if.o_ghash, P_RED);
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        check("sw_released", 128'({sw1_if.o_valid, sw4_if.o_valid, sw32_if.o_valid}), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ghash_digit_serial_ctrl.md
# ghash_digit_serial_ctrl

Digit-serial GHASH engine controller for the GCM authentication path. It accepts 128-bit blocks over a valid/ready handshake and sequences a GF(2^128) multiply-accumulate Y = (Y ^ X) · H over 128/NB_STEP cycles, processing NB_STEP multiplier bits per cycle with on-the-fly reduction by R = 0xE1‖0^120. It returns the final GHASH value of each message over a second valid/ready handshake. It sits between the block formatter (AAD / ciphertext / length-block stream) and the tag XOR stage.

## Interface
Parameters:
- NB_DATA, 128, block width; any other value is a bad configuration.
- NB_STEP, 8, multiplier bits consumed per cycle; legal values are 1, 2, 4, 8, 16, 32 (must divide 128).

Ports:
- i_clock  in  1  single clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_h_key  in  NB_DATA  hash subkey H.
- i_h_load  in  1  loads i_h_key into the H register; honoured only in IDLE.
- i_data  in  NB_DATA  input block X (GCM bit order: bit 127 = coefficient x^0).
- i_sop  in  1  with i_valid: first block of a message (Y treated as 0).
- i_eop  in  1  with i_valid: last block of a message (the length block).
- i_valid  in  1  input block valid.
- o_ready  out  1  input block ready.
- o_ghash  out  NB_DATA  GHASH result register.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream ready for the result.
- o_nblocks  out  32  block count of the reported message (see Configuration).

## Operation
- States: IDLE, MULT, OUT. o_ready = (state == IDLE).
- IDLE:
  - If i_h_load is high, H <= i_h_key.
  - On i_valid & o_ready, the block is accepted:
    - operand A <= i_data ^ (i_sop ? 0 : Y).
    - Z <= 0, V <= H (the newly loaded key if i_h_load is high in the same cycle), digit counter <= 0.
    - eop flag <= i_eop.
    - Go to MULT.
- MULT, one digit per cycle, MSB first. For each of the NB_STEP bits b = A[127-j], in order:
  - If b = 1, Z ^= V.
  - Then V = V[0] ? (V >> 1) ^ R : (V >> 1).
  - After the last digit (counter = 128/NB_STEP − 1), Y <= final Z.
  - Next state is OUT if the eop flag is set, else IDLE.
- OUT:
  - o_valid = 1 and o_ghash = Y, both held stable until i_ready is sampled high, then go to IDLE.
  - o_ghash keeps its last value in all other states.
- i_h_load is ignored in MULT and OUT. H is never altered mid-multiply.
- i_sop and i_eop high together: single-block message, result is i_data · H.
- A block without i_sop after a completed message chains from the Y of that message.
- Reset (asynchronous, at any time, including mid-MULT or in OUT):
  - State goes to IDLE; H, Y, Z, V, A and the counter go to 0.
  - Any in-flight block and result are discarded.
  - Output reset values: o_ready = 1, o_valid = 0, o_ghash = 0, o_nblocks = 0.

## Timing
- K = 128/NB_STEP, so K = 16 at the default.
- A block accepted at edge E0 holds o_ready low for cycles E0..E0+K−1.
- Non-eop block: o_ready returns high after edge E0+K. Sustained throughput is one block per K+1 cycles.
- Eop block: o_valid rises after edge E0+K. The earliest return to IDLE is one cycle later, when i_ready is high.
- o_ghash and o_valid come directly from registers, with no combinational path from the inputs. o_ready decodes state only.

## Configuration
- GHASH_CTRL_BLOCK_COUNT_EN defined:
  - A 32-bit saturating counter is reset to 1 on each i_sop acceptance and incremented on every other acceptance.
  - Its value for the eop block is captured into o_nblocks when entering OUT and held until the next capture or reset.
- GHASH_CTRL_BLOCK_COUNT_EN undefined: o_nblocks is constant 0 and no counter logic is present.

## Test plan
- Identity key: H = 0x8000…00, single block (sop, eop) X = 0x0123456789abcdef0011223344556677 -> o_ghash = X, o_valid rising after edge E0+16.
- Reduction: H = 0x000…01, X = 0x4000…00 -> o_ghash = 0xE1000000000000000000000000000000.
- Chaining: H = 0x8000…00, blocks X1 = 0xFF00…00 (sop) and X2 = 0x00FF…00 (eop) -> o_ghash = 0xFFFF00…00. With the macro defined, o_nblocks = 2. o_ready is low for 16 cycles after each acceptance.
- Backpressure: hold i_ready low for 10 cycles in OUT -> o_valid and o_ghash stay stable, o_ready stays 0, and a simultaneous i_h_load does not change H (check with a following identity-key block).
- Reset mid-MULT: assert i_reset at digit 5 -> all outputs take their reset values immediately. Then a new block with H = 0 -> o_ghash = 0.
- Sweep NB_STEP ∈ {1, 4, 32} on the reduction case -> the same o_ghash, with latency 128, 32 and 4 cycles respectively.
